// File: rtl/unsign_div_pkg.sv
// Shared types and constants for the unsigned sequential divider.
package unsign_div_pkg;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Default operand width
    localparam int DIV_WIDTH = 32;

    // Divide-by-zero results: quotient saturates to all ones, remainder is the dividend
    localparam logic [DIV_WIDTH-1:0] DIVZ_QUOT = {DIV_WIDTH{1'b1}};

    function automatic logic [DIV_WIDTH-1:0] divz_rem(input logic [DIV_WIDTH-1:0] dividend);
        return dividend;
    endfunction

endpackage

// File: rtl/unsign_seq_div_step.sv
// One combinational restoring-division iteration: shift {rem,quot} left,
// trial-subtract the divisor with a WIDTH+1-bit intermediate, keep or restore.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quot,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quot_next
);

    logic [WIDTH:0] shifted_rem;
    logic [WIDTH:0] trial;

    // Trial subtraction; the extra MSB keeps the bit shifted out of rem
    always_comb begin
        shifted_rem = {rem, quot[WIDTH-1]};
        trial       = shifted_rem - {1'b0, divisor};
        if (!trial[WIDTH]) begin
            rem_next  = trial[WIDTH-1:0];
            quot_next = {quot[WIDTH-2:0], 1'b1};
        end else begin
            rem_next  = shifted_rem[WIDTH-1:0];
            quot_next = {quot[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/unsign_seq_div.sv
// Unsigned sequential restoring divider, one quotient bit per clock.
// Optional macro DIV_EARLY_OUT_EN: divisor 0 or dividend < divisor finishes
// one cycle after the accept edge instead of running all WIDTH steps.
module unsign_seq_div
    import unsign_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             out_valid,
    output logic             busy,
    output logic             div_zero
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state_r;
    state_t           state_next;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] quot_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] divisor_r;
    logic             out_valid_r;
    logic             busy_r;
    logic             div_zero_r;
    logic             early_r;
    logic             accept_s;
    logic             early_s;
    logic [WIDTH-1:0] step_rem_s;
    logic [WIDTH-1:0] step_quot_s;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem       (rem_r),
        .quot      (quot_r),
        .divisor   (divisor_r),
        .rem_next  (step_rem_s),
        .quot_next (step_quot_s)
    );

    // Next-state decode: accept start in IDLE/DONE, finish RUN on the last step
    always_comb begin
        state_next = state_r;
        accept_s   = 1'b0;
        early_s    = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    accept_s   = 1'b1;
                    state_next = RUN;
`ifdef DIV_EARLY_OUT_EN
                    if ((in_b == {WIDTH{1'b0}}) || (in_a < in_b)) begin
                        early_s = 1'b1;
                    end else begin
                        early_s = 1'b0;
                    end
`endif
                end else begin
                    state_next = state_r;
                end
            end
            RUN: begin
                if (early_r || (cnt_r == LAST_CNT)) begin
                    state_next = DONE;
                end else begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, datapath registers and registered status outputs
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            quot_r      <= {WIDTH{1'b0}};
            rem_r       <= {WIDTH{1'b0}};
            divisor_r   <= {WIDTH{1'b0}};
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            div_zero_r  <= 1'b0;
            early_r     <= 1'b0;
        end else begin
            state_r     <= state_next;
            out_valid_r <= (state_next == DONE);
            busy_r      <= (state_next == RUN);
            if (accept_s) begin
                divisor_r  <= in_b;
                div_zero_r <= (in_b == {WIDTH{1'b0}});
                cnt_r      <= {CNT_W{1'b0}};
                early_r    <= early_s;
`ifdef DIV_EARLY_OUT_EN
                if (early_s && (in_b == {WIDTH{1'b0}})) begin
                    quot_r <= DIVZ_QUOT[WIDTH-1:0];
                    rem_r  <= in_a;
                end else if (early_s) begin
                    quot_r <= {WIDTH{1'b0}};
                    rem_r  <= in_a;
                end else begin
                    quot_r <= in_a;
                    rem_r  <= {WIDTH{1'b0}};
                end
`else
                quot_r <= in_a;
                rem_r  <= {WIDTH{1'b0}};
`endif
            end else if ((state_r == RUN) && !early_r) begin
                quot_r <= step_quot_s;
                rem_r  <= step_rem_s;
                cnt_r  <= cnt_r + CNT_W'(1);
            end else begin
                quot_r <= quot_r;
                rem_r  <= rem_r;
                cnt_r  <= cnt_r;
            end
        end
    end

    assign quot      = quot_r;
    assign rem       = rem_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign div_zero  = div_zero_r;

endmodule

// File: tb/tb_unsign_seq_div.sv
// Directed self-checking bench for unsign_seq_div.
module tb_unsign_seq_div;

    localparam int W = 32;

`ifdef DIV_EARLY_OUT_EN
    localparam int EARLY_LAT = 1;
`else
    localparam int EARLY_LAT = 32;
`endif

    logic         CLK;
    logic         reset;
    logic         start;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [W-1:0] quot;
    logic [W-1:0] rem;
    logic         out_valid;
    logic         busy;
    logic         div_zero;

    int tests_run = 0;
    int tests_failed = 0;

    unsign_seq_div dut (
        .CLK       (CLK),
        .reset     (reset),
        .start     (start),
        .in_a      (in_a),
        .in_b      (in_b),
        .quot      (quot),
        .rem       (rem),
        .out_valid (out_valid),
        .busy      (busy),
        .div_zero  (div_zero)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Pulse start for one edge; returns #1 after the accept edge
    task automatic do_start(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge CLK);
        in_a  = a;
        in_b  = b;
        start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        in_a  = 32'hDEAD_BEEF;
        in_b  = 32'h0000_0003;
    endtask

    // Count cycles until out_valid, bounded; -1 on timeout
    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 100) begin
            @(posedge CLK);
            #1;
            cycles++;
        end
        if (!out_valid) cycles = -1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        in_a  = 32'd0;
        in_b  = 32'd0;
        repeat (2) @(posedge CLK);
        #1;
        reset = 1'b0;
        tests_run++;
        if ({quot, rem, out_valid, busy, div_zero} !== {32'd0, 32'd0, 1'b0, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_state: got quot=%0h rem=%0h v=%0b busy=%0b dz=%0b, want all 0",
                     quot, rem, out_valid, busy, div_zero);
        end
    endtask

    task automatic test_basic();
        int cyc;
        do_start(32'd90, 32'd30);
        tests_run++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_busy: got busy=%0b v=%0b, want 1/0", busy, out_valid);
        end
        wait_valid(cyc);
        tests_run++;
        if (cyc !== 32) begin
            tests_failed++;
            $display("FAIL basic_latency: got %0d, want 32", cyc);
        end
        tests_run++;
        if (quot !== 32'd3 || rem !== 32'd0 || busy !== 1'b0 || div_zero !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_result: got q=%0d r=%0d busy=%0b dz=%0b, want 3 0 0 0", quot, rem, busy, div_zero);
        end
        repeat (3) @(posedge CLK);
        #1;
        tests_run++;
        if (quot !== 32'd3 || rem !== 32'd0 || out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_hold: got q=%0d r=%0d v=%0b, want 3 0 1", quot, rem, out_valid);
        end
    endtask

    task automatic test_max_by_one();
        int cyc;
        do_start(32'hFFFF_FFFF, 32'd1);
        tests_run++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL restart_from_done: got v=%0b busy=%0b, want 0 1", out_valid, busy);
        end
        wait_valid(cyc);
        tests_run++;
        if (cyc !== 32 || quot !== 32'hFFFF_FFFF || rem !== 32'd0) begin
            tests_failed++;
            $display("FAIL max_by_one: got cyc=%0d q=%0h r=%0h, want 32 ffffffff 0", cyc, quot, rem);
        end
    endtask

    task automatic test_max_by_max();
        int cyc;
        do_start(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_valid(cyc);
        tests_run++;
        if (cyc !== 32 || quot !== 32'd1 || rem !== 32'd0) begin
            tests_failed++;
            $display("FAIL max_by_max: got cyc=%0d q=%0h r=%0h, want 32 1 0", cyc, quot, rem);
        end
        do_start(32'hFFFF_FFFF, 32'hFFFF_FFFE);
        wait_valid(cyc);
        tests_run++;
        if (cyc !== 32 || quot !== 32'd1 || rem !== 32'd1) begin
            tests_failed++;
            $display("FAIL max_by_maxm1: got cyc=%0d q=%0h r=%0h, want 32 1 1", cyc, quot, rem);
        end
    endtask

    task automatic test_small_over_large();
        int cyc;
        do_start(32'd30, 32'd90);
        wait_valid(cyc);
        tests_run++;
        if (cyc !== EARLY_LAT || quot !== 32'd0 || rem !== 32'd30 || div_zero !== 1'b0) begin
            tests_failed++;
            $display("FAIL small_over_large: got cyc=%0d q=%0d r=%0d dz=%0b, want %0d 0 30 0",
                     cyc, quot, rem, div_zero, EARLY_LAT);
        end
    endtask

    task automatic test_div_zero();
        int cyc;
        do_start(32'd1000, 32'd0);
        wait_valid(cyc);
        tests_run++;
        if (cyc !== EARLY_LAT || quot !== 32'hFFFF_FFFF || rem !== 32'd1000 || div_zero !== 1'b1) begin
            tests_failed++;
            $display("FAIL div_zero: got cyc=%0d q=%0h r=%0d dz=%0b, want %0d ffffffff 1000 1",
                     cyc, quot, rem, div_zero, EARLY_LAT);
        end
        do_start(32'd100, 32'd9);
        tests_run++;
        if (div_zero !== 1'b0) begin
            tests_failed++;
            $display("FAIL div_zero_clear: got dz=%0b, want 0", div_zero);
        end
        wait_valid(cyc);
        tests_run++;
        if (cyc !== 32 || quot !== 32'd11 || rem !== 32'd1) begin
            tests_failed++;
            $display("FAIL after_zero: got cyc=%0d q=%0d r=%0d, want 32 11 1", cyc, quot, rem);
        end
    endtask

    task automatic test_reset_abort();
        int cyc;
        int seen;
        do_start(32'd77, 32'd7);
        repeat (9) @(posedge CLK);
        #1;
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL abort_busy: got busy=%0b, want 1", busy);
        end
        @(negedge CLK);
        reset = 1'b1;
        #1;
        tests_run++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || quot !== 32'd0 || rem !== 32'd0) begin
            tests_failed++;
            $display("FAIL async_reset: got busy=%0b v=%0b q=%0h r=%0h, want 0 0 0 0", busy, out_valid, quot, rem);
        end
        @(negedge CLK);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge CLK);
            #1;
            if (out_valid) seen++;
        end
        tests_run++;
        if (seen !== 0) begin
            tests_failed++;
            $display("FAIL abort_no_valid: got %0d valid cycles, want 0", seen);
        end
        do_start(32'd100, 32'd7);
        repeat (4) @(posedge CLK);
        @(negedge CLK);
        in_a  = 32'd5;
        in_b  = 32'd1;
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        @(posedge CLK);
        #1;
        cyc = 0;
        wait_valid(cyc);
        tests_run++;
        if (cyc !== 26 || quot !== 32'd14 || rem !== 32'd2) begin
            tests_failed++;
            $display("FAIL ignore_start_in_run: got cyc=%0d q=%0d r=%0d, want 26 14 2", cyc, quot, rem);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max_by_one();
        test_max_by_max();
        test_small_over_large();
        test_div_zero();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/unsign_seq_div.md
Name: unsign_seq_div

Overview:
- Sequential unsigned restoring divider, the inverse companion of the unsigned shift-add multiplier in the DDLab arithmetic set.
- Accepts dividend and divisor on a start strobe and retires one quotient bit per clock.
- Presents quotient and remainder with a level out_valid, using the same result/valid style as the multiplier so one bench style checks both.

Parameters:
- WIDTH, 32, operand width; quotient and remainder are also WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- CLK  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin division; sampled on a rising CLK edge.
- in_a  in  WIDTH  dividend.
- in_b  in  WIDTH  divisor.
- quot  out  WIDTH  quotient.
- rem  out  WIDTH  remainder.
- out_valid  out  1  quot and rem are valid.
- busy  out  1  division in progress.
- div_zero  out  1  last accepted divisor was 0.

Behaviour:
- Reset (async, active-high), all outputs and state cleared:
  - state=IDLE, quot=0, rem=0, out_valid=0, busy=0, div_zero=0, counter=0.
  - Reset mid-RUN aborts the division; no partial result is ever flagged valid.
- States and transitions: IDLE, RUN, DONE.
  - IDLE: start=1 latches in_a into the quotient shift register and in_b into the divisor register; rem accumulator cleared; cnt=0; go to RUN; busy=1.
  - RUN: each edge does one restoring step.
    - Shift {rem,quot} left by 1.
    - trial = shifted_rem (WIDTH+1 bits) - divisor.
    - trial non-negative: rem=trial[WIDTH-1:0], quot LSB=1. Otherwise rem=shifted_rem and quot LSB=0.
    - cnt increments each step. The step with cnt==WIDTH-1 is the last one and moves the block to DONE.
  - DONE: out_valid=1, busy=0. quot and rem are held stable until the next accepted start.
  - start in DONE is accepted exactly as in IDLE; out_valid falls on that same edge.
- start while in RUN is ignored; operands are not re-latched.
- Latency: start sampled at edge N, so out_valid=1 after edge N+WIDTH (32 cycles at default).
- Trial subtraction uses a WIDTH+1-bit intermediate so the shifted-out MSB is never lost. This matters for dividends and divisors at or near 2^WIDTH-1.
- Divisor 0: the algorithm runs normally. The natural result is quot=all ones and rem=dividend; div_zero=1 alongside out_valid. div_zero is cleared on the next accepted start.
- in_a and in_b may change freely after the start edge.
- Invariant when out_valid=1 and div_zero=0: quot*in_b + rem == in_a and rem < in_b.

Optional Feature:
- DIV_EARLY_OUT_EN defined: at the accept edge, if in_b==0 or in_a<in_b, go directly to DONE with results at the next edge (latency 1).
  - in_b==0 gives quot=all ones, rem=in_a, div_zero=1.
  - in_a<in_b gives quot=0, rem=in_a.
- DIV_EARLY_OUT_EN undefined: every division takes exactly WIDTH cycles, including these cases, with identical final results.

Decomposition:
- Package unsign_div_pkg:
  - state enum {IDLE, RUN, DONE}.
  - DIV_WIDTH=32.
  - Constants for the divide-by-zero results (quotient all ones, remainder = dividend).
- One sub-module, div_step: purely combinational single restoring iteration.
  - Inputs: rem, quot, divisor.
  - Outputs: next rem, next quot.
  - The FSM/counter wrapper instantiates it once.

Test Plan:
- 90 / 30 -> quot=3, rem=0, out_valid exactly 32 cycles after start.
- 4294967295 / 1 -> quot=4294967295, rem=0.
- 4294967295 / 4294967295 -> quot=1, rem=0; checks the WIDTH+1-bit trial MSB path.
- 30 / 90 -> quot=0, rem=30 (latency 32, or 1 with DIV_EARLY_OUT_EN).
- 1000 / 0 -> quot=32'hFFFFFFFF, rem=1000, div_zero=1.
- 77 / 7 started, reset pulsed at cycle 10, then 100 / 7 started -> no out_valid from the first job; second gives quot=14, rem=2. A second start during RUN is ignored.
